// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath with memory wait states.
// Define MC_EXT_OPS_EN to add bne and addi support.
module multicycle_ctrl #(
  parameter int WAIT_CYCLES = 0,
  parameter int ALUCTRL_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 PCEn,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           PCSrc,
  output logic                 illegal,
  output logic                 instr_done,
  output logic [3:0]           state
);

  localparam int CW = (WAIT_CYCLES > 0) ?
                      $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_CYCLES);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_EXT_OPS_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b111);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
`ifdef MC_EXT_OPS_EN
    , S_ADDIEX = 4'd10
    , S_ADDIWB = 4'd11
`endif
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   wait_cnt;
  logic            mem_st;
  logic            wait_done;
  logic            ill_q;
  logic            dec_ill;
  logic            funct_ok;
  logic [ALUCTRL_W-1:0] alu_fn;
  logic            is_bne;
  logic            pc_write;
  logic            branch;

  logic op_r, op_lw, op_sw, op_beq, op_j;
  logic op_bne, op_addi;

  assign op_r   = (opcode == OP_R);
  assign op_lw  = (opcode == OP_LW);
  assign op_sw  = (opcode == OP_SW);
  assign op_beq = (opcode == OP_BEQ);
  assign op_j   = (opcode == OP_J);
`ifdef MC_EXT_OPS_EN
  assign op_bne  = (opcode == OP_BNE);
  assign op_addi = (opcode == OP_ADDI);
  assign is_bne  = op_bne;
`else
  assign op_bne  = 1'b0;
  assign op_addi = 1'b0;
  assign is_bne  = 1'b0;
`endif

  always_comb begin
    funct_ok = 1'b1;
    alu_fn   = ALU_ADD;
    unique case (funct)
      6'b100000: alu_fn = ALU_ADD;
      6'b100010: alu_fn = ALU_SUB;
      6'b100100: alu_fn = ALU_AND;
      6'b100101: alu_fn = ALU_OR;
      6'b101010: alu_fn = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign mem_st = (state_q == S_FETCH) ||
                  (state_q == S_MEMREAD) ||
                  (state_q == S_MEMWRITE);
  assign wait_done = (wait_cnt == WAIT_MAX);

  assign dec_ill = !(op_lw || op_sw || op_beq || op_j ||
                     (op_r && funct_ok) ||
                     op_bne || op_addi);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_st && !wait_done)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;
      ill_q <= (state_q == S_DECODE) && dec_ill;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op_lw, op_sw:       state_d = S_MEMADR;
          op_r && funct_ok:   state_d = S_EXECUTE;
          op_beq:             state_d = S_BRANCH;
          op_j:               state_d = S_JUMP;
`ifdef MC_EXT_OPS_EN
          op_bne:             state_d = S_BRANCH;
          op_addi:            state_d = S_ADDIEX;
`endif
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = op_sw ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (wait_done) state_d = S_MEMWB;
      S_MEMWRITE:
        if (wait_done) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
`ifdef MC_EXT_OPS_EN
      S_ADDIEX:  state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    instr_done = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = wait_done;
        pc_write = wait_done;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = wait_done;
        instr_done = wait_done;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = alu_fn;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef MC_EXT_OPS_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
    PCEn = pc_write | (branch & (zero ^ is_bne));
    // Reset is synchronous for state but must blank outputs immediately.
    if (reset) begin
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = '0;
      PCSrc      = 2'b00;
      instr_done = 1'b0;
    end
  end

  assign illegal = ill_q & ~reset;
  assign state   = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (W=0, W=2) driven by random
// instruction streams and checked cycle by cycle against a phase-list model.
module tb_multicycle_ctrl;

  localparam int W1 = 2;
`ifdef MC_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
    logic [1:0] pcsrc;
    logic       illegal;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_a    [2];
  logic [5:0] opcode_a   [2];
  logic [5:0] funct_a    [2];
  logic       zero_a     [2];
  logic       pcen_a     [2];
  logic       iord_a     [2];
  logic       memwrite_a [2];
  logic       irwrite_a  [2];
  logic       regdst_a   [2];
  logic       memtoreg_a [2];
  logic       regwrite_a [2];
  logic       alusrca_a  [2];
  logic [1:0] alusrcb_a  [2];
  logic [2:0] aluctl_a   [2];
  logic [1:0] pcsrc_a    [2];
  logic       illegal_a  [2];
  logic       done_a     [2];
  logic [3:0] state_a    [2];

  exp_t exp_q [2][$];
  bit   pend_ill [2];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_ctrl #(
      .WAIT_CYCLES(g == 0 ? 0 : W1),
      .ALUCTRL_W(3)
    ) u_dut (
      .clk(clk),
      .reset(reset_a[g]),
      .opcode(opcode_a[g]),
      .funct(funct_a[g]),
      .zero(zero_a[g]),
      .PCEn(pcen_a[g]),
      .IorD(iord_a[g]),
      .MemWrite(memwrite_a[g]),
      .IRWrite(irwrite_a[g]),
      .RegDst(regdst_a[g]),
      .MemtoReg(memtoreg_a[g]),
      .RegWrite(regwrite_a[g]),
      .ALUSrcA(alusrca_a[g]),
      .ALUSrcB(alusrcb_a[g]),
      .ALUControl(aluctl_a[g]),
      .PCSrc(pcsrc_a[g]),
      .illegal(illegal_a[g]),
      .instr_done(done_a[g]),
      .state(state_a[g])
    );
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] fn,
                                        output bit ok);
    ok = 1'b1;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin ok = 1'b0; return 3'b000; end
    endcase
  endfunction

  // Expected output vector for every cycle of one instruction.
  function automatic void build(input int w, input logic [5:0] op,
                                input logic [5:0] fn, input logic z,
                                output exp_t seq[$], output bit ill);
    exp_t e;
    bit fok;
    logic [2:0] a;
    seq.delete();
    ill = 1'b0;
    a = alu_of(fn, fok);
    for (int i = 0; i <= w; i++) begin
      e = '0; e.alusrcb = 2'b01; e.aluctl = 3'b010;
      e.irwrite = (i == w); e.pcen = (i == w);
      seq.push_back(e);
    end
    e = '0; e.alusrcb = 2'b11; e.aluctl = 3'b010;
    seq.push_back(e);
    if (op == LW || op == SW) begin
      e = '0; e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010;
      seq.push_back(e);
      for (int i = 0; i <= w; i++) begin
        e = '0; e.aluctl = 3'b010; e.iord = 1;
        if (op == SW) begin
          e.memwrite = (i == w); e.done = (i == w);
        end
        seq.push_back(e);
      end
      if (op == LW) begin
        e = '0; e.aluctl = 3'b010;
        e.memtoreg = 1; e.regwrite = 1; e.done = 1;
        seq.push_back(e);
      end
    end else if (op == R && fok) begin
      e = '0; e.alusrca = 1; e.aluctl = a;
      seq.push_back(e);
      e = '0; e.aluctl = 3'b010; e.regdst = 1; e.regwrite = 1; e.done = 1;
      seq.push_back(e);
    end else if (op == BEQ || (EXT && op == BNE)) begin
      e = '0; e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01;
      e.pcen = (op == BEQ) ? z : !z; e.done = 1;
      seq.push_back(e);
    end else if (op == J) begin
      e = '0; e.aluctl = 3'b010; e.pcsrc = 2'b10; e.pcen = 1; e.done = 1;
      seq.push_back(e);
    end else if (EXT && op == ADDI) begin
      e = '0; e.alusrca = 1; e.alusrcb = 2'b10; e.aluctl = 3'b010;
      seq.push_back(e);
      e = '0; e.aluctl = 3'b010; e.regwrite = 1; e.done = 1;
      seq.push_back(e);
    end else begin
      ill = 1'b1;
    end
  endfunction

  // abort_at: -1 none, -2 random cycle, >=0 reset during that cycle.
  task automatic issue(input int k, input logic [5:0] op,
                       input logic [5:0] fn, input logic z,
                       input int abort_at);
    exp_t seq[$];
    bit ill;
    int w;
    w = (k == 0) ? 0 : W1;
    build(w, op, fn, z, seq, ill);
    if (pend_ill[k]) begin
      seq[0].illegal = 1'b1;
      pend_ill[k] = 1'b0;
    end
    if (abort_at == -2)
      abort_at = $urandom_range(1, seq.size() - 1);
    opcode_a[k] = op;
    funct_a[k]  = fn;
    zero_a[k]   = z;
    if (abort_at >= 0) begin
      while (seq.size() > abort_at) void'(seq.pop_back());
      seq.push_back('0);
      foreach (seq[i]) exp_q[k].push_back(seq[i]);
      repeat (abort_at) @(posedge clk);
      #1 reset_a[k] = 1'b1;
      @(posedge clk);
      #1 reset_a[k] = 1'b0;
    end else begin
      foreach (seq[i]) exp_q[k].push_back(seq[i]);
      pend_ill[k] = ill;
      repeat (seq.size()) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] good_funct();
    logic [5:0] t [5];
    t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    return t[$urandom_range(0, 4)];
  endfunction

  task automatic drive(input int k);
    int w;
    int r;
    logic [5:0] op;
    logic [5:0] fn;
    w = (k == 0) ? 0 : W1;
    issue(k, R, 6'b100010, 1'b0, -1);
    issue(k, LW, 6'b000000, 1'b0, -1);
    issue(k, SW, 6'b000000, 1'b0, -1);
    issue(k, BEQ, 6'b000000, 1'b1, -1);
    issue(k, BEQ, 6'b000000, 1'b0, -1);
    issue(k, 6'b111111, 6'b000000, 1'b0, -1);
    issue(k, J, 6'b000000, 1'b0, -1);
    issue(k, BNE, 6'b000000, 1'b0, -1);
    issue(k, ADDI, 6'b000000, 1'b0, -1);
    issue(k, R, 6'b000111, 1'b0, -1);
    issue(k, SW, 6'b000000, 1'b0, w + 3 + (w > 0 ? 1 : 0));
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 8);
      fn = good_funct();
      case (r)
        0: op = R;
        1: begin op = R; fn = 6'($urandom); end
        2: op = LW;
        3: op = SW;
        4: op = BEQ;
        5: op = J;
        6: op = BNE;
        7: op = ADDI;
        default: op = 6'($urandom);
      endcase
      issue(k, op, fn, 1'($urandom),
            ($urandom_range(0, 14) == 0) ? -2 : -1);
    end
    issue(k, J, 6'b000000, 1'b0, -1);
  endtask

  initial begin : compare
    exp_t a;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (exp_q[k].size() > 0) begin
          e = exp_q[k].pop_front();
          a = {pcen_a[k], iord_a[k], memwrite_a[k], irwrite_a[k],
               regdst_a[k], memtoreg_a[k], regwrite_a[k], alusrca_a[k],
               alusrcb_a[k], aluctl_a[k], pcsrc_a[k], illegal_a[k],
               done_a[k]};
          n_checks++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL cycle_outputs inst%0d t=%0t: got %h, expected %h",
                     k, $time, a, e);
          end
        end
      end
    end
  end

  initial begin : main
    exp_t s[$];
    bit ill;
    for (int k = 0; k < 2; k++) begin
      reset_a[k]  = 1'b1;
      opcode_a[k] = '0;
      funct_a[k]  = '0;
      zero_a[k]   = 1'b0;
      pend_ill[k] = 1'b0;
      exp_q[k].push_back('0);
    end
    build(0, R, 6'b100010, 1'b0, s, ill);
    check("model_rtype_len_w0", s.size(), 4);
    check("model_rtype_sub", int'(s[2].aluctl), 6);
    check("model_fetch_irwrite", int'(s[0].irwrite), 1);
    build(W1, LW, 6'b000000, 1'b0, s, ill);
    check("model_lw_len_w2", s.size(), 9);
    check("model_lw_fetch1_irwrite", int'(s[1].irwrite), 0);
    check("model_lw_memread_iord", int'(s[5].iord), 1);
    build(W1, SW, 6'b000000, 1'b0, s, ill);
    check("model_sw_len_w2", s.size(), 8);
    build(0, BEQ, 6'b000000, 1'b0, s, ill);
    check("model_beq_nt_pcen", int'(s[2].pcen), 0);
    build(0, 6'b111111, 6'b000000, 1'b0, s, ill);
    check("model_illegal_flag", int'(ill), 1);
    repeat (2) @(posedge clk);
    #1;
    reset_a[0] = 1'b0;
    reset_a[1] = 1'b0;
    fork
      drive(0);
      drive(1);
    join
    @(negedge clk);
    check("queue0_drained", exp_q[0].size(), 0);
    check("queue1_drained", exp_q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
